// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion-estimation constants, types and helpers
package me_pkg;

  localparam int ME_MACRO_DIM  = 16;
  localparam int ME_SEARCH_DIM = 48;

  // Lossless SAD width: 8-bit entries summed over MACRO_DIM^2 terms.
  localparam int SAD_W = 8 + 2 * $clog2(ME_MACRO_DIM);
  localparam int MV_W  = 6;

  // Candidate positions per search-window axis.
  function automatic int num_cand(input int macro_dim, input int search_dim);
    return search_dim - macro_dim + 1;
  endfunction

  typedef struct packed {
    logic signed [MV_W-1:0] mvx;
    logic signed [MV_W-1:0] mvy;
  } mv_t;

  // Sideband that travels with a candidate's partial sums.
  typedef struct packed {
    mv_t  mv;
    logic last;
    logic valid;
  } cand_tag_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } search_state_t;

endpackage

// File: rtl/sad_adder_tree.sv
// rtl/sad_adder_tree.sv - pipelined SAD adder tree with candidate tag sideband
module sad_adder_tree
  import me_pkg::*;
#(
  parameter int N_IN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [8*N_IN-1:0] ad,
  input  cand_tag_t         tag_in,
  output logic [SAD_W-1:0]  sum,
  output cand_tag_t         tag_out
);

  // Every register stage folds groups of four operands, i.e. two adder levels.
  localparam int STAGES = $clog2(N_IN) / 2;

  // Offset of a stage's first node in the flat node array.
  function automatic int stage_ofs(input int s);
    int o;
    o = 0;
    for (int j = 0; j < s; j++) o += N_IN >> (2 * (j + 1));
    return o;
  endfunction

  localparam int TOTAL = stage_ofs(STAGES);

  logic [SAD_W-1:0] node   [TOTAL];
  logic [SAD_W-1:0] node_d [TOTAL];
  cand_tag_t        tag_q  [STAGES];

  // Next value of every tree node: stage 0 reads the raw entries, later stages the prior stage.
  always_comb begin
    logic [SAD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < TOTAL; i++) node_d[i] = '0;
    for (int i = 0; i < N_IN / 4; i++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) acc = acc + SAD_W'(ad[8*(4*i+j) +: 8]);
      node_d[i] = acc;
    end
    for (int s = 1; s < STAGES; s++) begin
      for (int i = 0; i < (N_IN >> (2 * (s + 1))); i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc + node[stage_ofs(s - 1) + 4*i + j];
        node_d[stage_ofs(s) + i] = acc;
      end
    end
  end

  // Data registers run free; whether a value means anything lives only in the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOTAL; i++) node[i] <= '0;
    end else begin
      for (int i = 0; i < TOTAL; i++) node[i] <= node_d[i];
    end
  end

  // Tag shift register matching the data latency; flush kills every in-flight candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
      if (flush) begin
        for (int s = 0; s < STAGES; s++) tag_q[s].valid <= 1'b0;
      end
    end
  end

  assign sum     = node[TOTAL-1];
  assign tag_out = tag_q[STAGES-1];

endmodule

// File: rtl/sad_min_search.sv
// rtl/sad_min_search.sv - minimum-SAD motion vector search; SAD_ZMV_BIAS_EN enables zero-MV bias
module sad_min_search
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = ME_MACRO_DIM,
  parameter int SEARCH_DIM = ME_SEARCH_DIM
`ifdef SAD_ZMV_BIAS_EN
  , parameter int ZMV_BIAS = 16
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               ad_valid,
  input  logic [8*MACRO_DIM*MACRO_DIM-1:0]   ad,
  output logic [SAD_W-1:0]                   sad,
  output logic                               sad_valid,
  output logic [SAD_W-1:0]                   best_sad,
  output logic signed [MV_W-1:0]             best_mvx,
  output logic signed [MV_W-1:0]             best_mvy,
  output logic                               busy,
  output logic                               done
);

  localparam int            N        = num_cand(MACRO_DIM, SEARCH_DIM);
  localparam int            R        = (N - 1) / 2;
  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  search_state_t    state;
  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic             fed_all;
  logic             have_best;
  logic             accept;
  cand_tag_t        tag_in;
  cand_tag_t        tree_tag;
  logic [SAD_W-1:0] tree_sum;
  logic [SAD_W-1:0] cmp_sad;
  mv_t              best_mv;

  // A start in the same cycle wins over the beat: that beat belongs to no search.
  assign accept = (state == S_SCAN) && !start && ad_valid && !fed_all;

  // Tag for the beat entering the tree: column-major scan position mapped to a centred MV.
  always_comb begin
    tag_in        = '0;
    tag_in.mv.mvx = MV_W'(col) - MV_W'(R);
    tag_in.mv.mvy = MV_W'(row) - MV_W'(R);
    tag_in.last   = (col == LAST_IDX) && (row == LAST_IDX);
    tag_in.valid  = accept;
  end

  sad_adder_tree #(
    .N_IN (MACRO_DIM * MACRO_DIM)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .flush   (start),
    .ad      (ad),
    .tag_in  (tag_in),
    .sum     (tree_sum),
    .tag_out (tree_tag)
  );

  assign sad       = tree_sum;
  assign sad_valid = tree_tag.valid;
  assign best_mvx  = best_mv.mvx;
  assign best_mvy  = best_mv.mvy;

  // Value used in the comparison; the zero vector may be favoured by a fixed bias.
  always_comb begin
    cmp_sad = tree_sum;
`ifdef SAD_ZMV_BIAS_EN
    if (tree_tag.mv == '0) begin
      cmp_sad = (tree_sum > SAD_W'(ZMV_BIAS)) ? tree_sum - SAD_W'(ZMV_BIAS) : '0;
    end
`endif
  end

  // Search FSM: beat counter, best tracker and the busy/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      fed_all   <= 1'b0;
      have_best <= 1'b0;
      best_sad  <= '1;
      best_mv   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
        end
        S_SCAN: begin
          if (!start) begin
            if (accept) begin
              if (row == LAST_IDX) begin
                row <= '0;
                if (col == LAST_IDX) fed_all <= 1'b1;
                else                 col     <= col + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end
            if (tree_tag.valid) begin
              // Strict less-than keeps the earliest candidate on ties.
              if (!have_best || cmp_sad < best_sad) begin
                best_sad <= cmp_sad;
                best_mv  <= tree_tag.mv;
              end
              have_best <= 1'b1;
              if (tree_tag.last) state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (start) begin
        state     <= S_SCAN;
        busy      <= 1'b1;
        col       <= '0;
        row       <= '0;
        fed_all   <= 1'b0;
        have_best <= 1'b0;
        best_sad  <= '1;
        best_mv   <= '0;
      end
    end
  end

endmodule

// File: doc/sad_min_search.md
# sad_min_search

Downstream of the PE matrix in the inter-prediction (motion estimation) path. Consumes the per-candidate absolute-difference vector `ad` and reduces it to a SAD through a pipelined adder tree. Scans all candidate positions of one search window and tracks the minimum SAD and its motion vector. Reports the winner to the mode decision stage with a one-cycle `done` pulse.

## Interface
- `MACRO_DIM`, 16: macroblock edge in pixels; `ad` carries MACRO_DIM² 8-bit entries.
- `SEARCH_DIM`, 48: search window edge; candidates per axis N = SEARCH_DIM−MACRO_DIM+1 (33).
- `ZMV_BIAS`, 16: zero-MV bias; used only when the macro is defined.
- `clk`  in  1  clock; one clock, reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a new window search; clears the tracker.
- `ad_valid`  in  1  `ad` holds the current candidate's differences.
- `ad`  in  8*MACRO_DIM²  absolute differences; entry k at bits [8k+7:8k].
- `sad`  out  SAD_W (16)  SAD of the most recent candidate.
- `sad_valid`  out  1  `sad` is valid this cycle.
- `best_sad`  out  SAD_W  minimum SAD so far.
- `best_mvx`, `best_mvy`  out  MV_W (6) each, signed  MV of `best_sad`, range ±R where R=(N−1)/2.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle pulse; `best_*` final and held.

## Operation
- FSM states: IDLE → (start) → SCAN → (last candidate's SAD compared) → DONE → IDLE next cycle.
- `ad_valid` beats are accepted only in SCAN. Beat index c counts 0..N²−1. Column = c / N is the outer loop and row = c mod N is the inner loop. Candidate MV: mvx = column−R, mvy = row−R.
- The tree sums all MACRO_DIM² entries without truncation. SAD_W = 8+2·log2(MACRO_DIM).
- A candidate's tag (mvx, mvy, last flag) travels down the pipeline alongside its partial sums.
- Compare at tree output:
  - The first SAD of a search is loaded unconditionally.
  - After that, a SAD replaces the best only if it is strictly less. On ties, the earliest candidate in scan order wins.
- `ad_valid` beats beyond N² in SCAN are ignored. `ad_valid` in IDLE or DONE is ignored.
- A `start` while in SCAN aborts the current search:
  - Beat counter and best registers are cleared.
  - In-flight pipeline tags are invalidated, so stale SADs from the aborted search are never compared.
  - No `done` is produced for the aborted search.
- `start` in DONE takes effect as from IDLE.
- `best_*` holds its value after `done` until the next `start`.

## Timing
- Tree: 8 adder levels, registered every 2 levels. `sad_valid` asserts 4 cycles after the `ad_valid` beat that carried the candidate.
- Throughput: one candidate per cycle, with no back-pressure.
- `best_*` updates the cycle after `sad_valid`.
- `done` asserts the cycle after `best_*` reflects the final candidate, i.e. 6 cycles after the last beat.
- `busy` rises the cycle after `start` and falls together with `done`.
- Reset values: `sad`=0, `sad_valid`=0, `best_sad`=all-ones, `best_mvx`=`best_mvy`=0, `busy`=0, `done`=0, FSM=IDLE. Pipeline valid bits are cleared.
- `rst` mid-search discards everything; no `done` is produced.

## Configuration
- `SAD_ZMV_BIAS_EN` defined:
  - Candidate (0,0) is compared as max(SAD−ZMV_BIAS, 0).
  - The stored `best_sad` is that biased value.
  - The `sad` output stays unbiased.
- `SAD_ZMV_BIAS_EN` undefined: all candidates are compared unbiased, and `ZMV_BIAS` is unused.

## Structure
- Shared package `me_pkg`:
  - Constants SAD_W, MV_W.
  - Function `num_cand(MACRO_DIM, SEARCH_DIM)`.
  - Typedef `mv_t` (signed mvx/mvy struct).
  - Typedef `cand_tag_t` (mv_t, last, valid).
- Sub-module `sad_adder_tree`: parameterised pipelined reduction. It carries a `cand_tag_t` sideband with matching latency and has a flush input used on abort.

## Test plan
- All `ad`=0x01, full 1089-beat scan → every `sad`=256. `best_sad`=256 with MV (−16,−16), the first candidate, due to the tie rule. `done` comes 6 cycles after the last beat.
- All `ad`=0x10, except beat 544 (column 16, row 16) which is all 0x02 → `best_sad`=512 with MV (0,0).
  - With `SAD_ZMV_BIAS_EN`: `best_sad`=496.
- All `ad` entries 0xFF on a single beat → `sad`=65280 with no overflow.
- `start` asserted mid-scan at beat 300, then a full 1089-beat rescan → exactly one `done`. The result reflects only the second scan.
- `ad_valid` toggling every other cycle → same result as back-to-back. Extra beats after 1089 → no change, no second `done`.
- `rst` asserted at beat 500 → all outputs return to reset values next cycle. A subsequent `start` and full scan completes normally.
